fifo_control_param: RTL and testbench

Parametrised FIFO controller that generates write/read pointers, occupancy count and status flags for an external dual-port RAM of depth DEPTH. It sits between producer/consumer request lines and the FIFO storage, gating requests that would overflow or underflow. Thresholds are programmable at run time, and overflow/underflow errors are optionally captured as sticky flags.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ptr.sv | 39 +++
 rtl/fifo_control_param.sv | 133 +++++++++++++
 tb/tb_fifo_control_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO controller files.
//   DEPTH_DEF    - default number of FIFO entries
//   cnt_w_f()    - width that can hold any occupancy 0..depth
//   fifo_flags_t - bundle of the four status flags decoded from the count
package fifo_pkg;

  localparam int DEPTH_DEF = 8;

  // One more bit than the address so that a completely full FIFO (count == depth)
  // is representable.
  function automatic int cnt_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: ADDR_W-bit RAM address pointer that advances on en and wraps
// DEPTH-1 -> 0.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset, clears the pointer to 0
//   en    - advance the pointer at this edge
//   ptr   - registered pointer value
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_r;

  // Pointer register with explicit modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (en) begin
      if (ptr_r == ADDR_W'(DEPTH - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= ptr_r + ADDR_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_control_param.sv
// fifo_control_param: FIFO controller for an external dual-port RAM of DEPTH entries.
// Gates producer/consumer requests against full/empty, keeps the RAM pointers and
// occupancy count, decodes status flags against run-time thresholds and reports
// overflow/underflow attempts.
// Build option: FIFO_CTRL_ERR_STICKY_EN
//   defined   - overflow/underflow are sticky until err_clr (a coincident set wins)
//   undefined - overflow/underflow are one-cycle pulses, err_clr is ignored
// Ports:
//   clk, reset                 - clock; asynchronous active-low reset
//   fifo_wr, fifo_rd           - write / read requests
//   full_umbral, empty_umbral  - almost_full / almost_empty thresholds (unsigned)
//   err_clr                    - clears sticky error flags
//   mem_wr_en, mem_rd_en       - accepted write / read this cycle (zero latency)
//   wr_ptr, rd_ptr             - RAM write / read addresses
//   count                      - occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty - status decoded from count
//   overflow, underflow        - error flags
module fifo_control_param
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic [CNT_W-1:0]  full_umbral,
  input  logic [CNT_W-1:0]  empty_umbral,
  input  logic              err_clr,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  logic [CNT_W-1:0] count_r;
  fifo_flags_t      flags_s;
  logic             mem_wr_en_s;
  logic             mem_rd_en_s;
  logic             overflow_r;
  logic             underflow_r;

  // Status flags decode straight from the registered count, so threshold changes
  // show up in the same cycle.
  always_comb begin
    flags_s              = '0;
    flags_s.full         = (count_r == CNT_W'(DEPTH));
    flags_s.empty        = (count_r == CNT_W'(0));
    flags_s.almost_full  = (count_r >= full_umbral);
    flags_s.almost_empty = (count_r <= empty_umbral);
  end

  // Request gating: full blocks writes and empty blocks reads, even when the
  // opposite request would make room in the same cycle.
  always_comb begin
    mem_wr_en_s = fifo_wr & ~flags_s.full;
    mem_rd_en_s = fifo_rd & ~flags_s.empty;
  end

  // Occupancy counter; a simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else begin
      case ({mem_wr_en_s, mem_rd_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_STICKY_EN
  // Sticky error capture; a new offending request takes priority over err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (fifo_wr & flags_s.full)  | (overflow_r  & ~err_clr);
      underflow_r <= (fifo_rd & flags_s.empty) | (underflow_r & ~err_clr);
    end
  end
`else
  logic err_clr_unused_s;
  assign err_clr_unused_s = err_clr;

  // One-cycle error pulses in the cycle after the offending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= fifo_wr & flags_s.full;
      underflow_r <= fifo_rd & flags_s.empty;
    end
  end
`endif

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (mem_wr_en_s),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (mem_rd_en_s),
    .ptr   (rd_ptr)
  );

  assign mem_wr_en    = mem_wr_en_s;
  assign mem_rd_en    = mem_rd_en_s;
  assign count        = count_r;
  assign full         = flags_s.full;
  assign empty        = flags_s.empty;
  assign almost_full  = flags_s.almost_full;
  assign almost_empty = flags_s.almost_empty;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_control_param.sv
// Testbench for fifo_control_param. Stimulus pushes the expected outputs of each
// cycle into a scoreboard queue; a negedge monitor pops and compares. The reference
// model keeps the FIFO contents as a queue and the pointers as running totals.
module tb_fifo_control_param;

  localparam int D = 8;

  typedef struct packed {
    logic       wen;
    logic       ren;
    logic [2:0] wp;
    logic [2:0] rp;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_wr, fifo_rd, err_clr;
  logic [3:0] full_umbral, empty_umbral;
  logic       mem_wr_en, mem_rd_en;
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  logic       wr16;
  logic [4:0] fu16, eu16;
  logic       wen16, ren16, full16, empty16, af16, ae16, ovf16, unf16;
  logic [3:0] wp16, rp16;
  logic [4:0] count16;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];

  // reference model state
  int   mq[$];
  int   wr_total, rd_total;
  bit   ovf_m, unf_m;

  always #5 clk = ~clk;

  fifo_control_param #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .full_umbral(full_umbral), .empty_umbral(empty_umbral), .err_clr(err_clr),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  fifo_control_param #(.DEPTH(16)) dut16 (
    .clk(clk), .reset(reset), .fifo_wr(wr16), .fifo_rd(1'b0),
    .full_umbral(fu16), .empty_umbral(eu16), .err_clr(1'b0),
    .mem_wr_en(wen16), .mem_rd_en(ren16), .wr_ptr(wp16), .rd_ptr(rp16),
    .count(count16), .full(full16), .empty(empty16), .almost_full(af16),
    .almost_empty(ae16), .overflow(ovf16), .underflow(unf16)
  );

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endfunction

  // Scoreboard monitor: compares every field of the expected record for this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        check("sb_underrun", 0, 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mem_wr_en",    int'(mem_wr_en),    int'(e.wen));
        check("mem_rd_en",    int'(mem_rd_en),    int'(e.ren));
        check("wr_ptr",       int'(wr_ptr),       int'(e.wp));
        check("rd_ptr",       int'(rd_ptr),       int'(e.rp));
        check("count",        int'(count),        int'(e.cnt));
        check("full",         int'(full),         int'(e.full));
        check("empty",        int'(empty),        int'(e.empty));
        check("almost_full",  int'(almost_full),  int'(e.af));
        check("almost_empty", int'(almost_empty), int'(e.ae));
        check("overflow",     int'(overflow),     int'(e.ovf));
        check("underflow",    int'(underflow),    int'(e.unf));
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    wr_total = 0;
    rd_total = 0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
  endtask

  // One cycle: apply inputs, predict outputs, advance the model, wait for the edge.
  task automatic step(input bit w, input bit r, input int f, input int e, input bit c);
    exp_t x;
    int   cnt;
    bit   is_full, is_empty, acc_w, acc_r;
    fifo_wr      = w;
    fifo_rd      = r;
    full_umbral  = 4'(f);
    empty_umbral = 4'(e);
    err_clr      = c;
    cnt      = mq.size();
    is_full  = (cnt == D);
    is_empty = (cnt == 0);
    acc_w    = w && !is_full;
    acc_r    = r && !is_empty;
    x.wen   = acc_w;
    x.ren   = acc_r;
    x.wp    = 3'(wr_total % D);
    x.rp    = 3'(rd_total % D);
    x.cnt   = 4'(cnt);
    x.full  = is_full;
    x.empty = is_empty;
    x.af    = (cnt >= f);
    x.ae    = (cnt <= e);
    x.ovf   = ovf_m;
    x.unf   = unf_m;
    sb_q.push_back(x);
    if (acc_r) void'(mq.pop_front());
    if (acc_w) mq.push_back($urandom);
    wr_total += int'(acc_w);
    rd_total += int'(acc_r);
`ifdef FIFO_CTRL_ERR_STICKY_EN
    ovf_m = (w && is_full)  || (ovf_m && !c);
    unf_m = (r && is_empty) || (unf_m && !c);
`else
    ovf_m = w && is_full;
    unf_m = r && is_empty;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0; err_clr = 1'b0;
    full_umbral = 4'd6; empty_umbral = 4'd1;
    wr16 = 1'b0; fu16 = 5'd20; eu16 = 5'd2;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_wr_ptr", int'(wr_ptr), 0);
    check("rst_rd_ptr", int'(rd_ptr), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_almost_empty", int'(almost_empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_almost_full", int'(almost_full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_underflow", int'(underflow), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // fill to full with thresholds 6 / 1
    for (int i = 0; i < 8; i++) step(1, 0, 6, 1, 0);
    // overflow attempt, then observe, then clear
    step(1, 0, 6, 1, 0);
    step(0, 0, 6, 1, 0);
    step(0, 0, 6, 1, 0);
    step(0, 0, 6, 1, 1);
    step(0, 0, 6, 1, 0);
    // drain to empty
    for (int i = 0; i < 8; i++) step(0, 1, 6, 1, 0);
    // read+write at empty: write accepted, read rejected
    step(1, 1, 6, 1, 0);
    step(0, 0, 6, 1, 0);
    step(0, 0, 6, 1, 0);
    step(0, 0, 6, 1, 1);
    // bring to 4, then 10 cycles of simultaneous read/write
    for (int i = 0; i < 3; i++) step(1, 0, 6, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 6, 1, 0);
    step(1, 0, 6, 1, 0);
    step(0, 0, 6, 1, 0);

    // asynchronous reset with count = 5, checked before the next edge
    mon_en = 1'b0;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_wr_ptr", int'(wr_ptr), 0);
    check("arst_rd_ptr", int'(rd_ptr), 0);
    check("arst_empty", int'(empty), 1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // randomized traffic with random thresholds and clears
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
           ($urandom_range(0, 9) == 0));
    end
    step(0, 0, 6, 1, 0);
    mon_en = 1'b0;

    // DEPTH=16 with full_umbral=20: almost_full never asserts, full at 16
    for (int i = 0; i < 18; i++) begin
      wr16 = 1'b1;
      @(negedge clk);
      check("d16_count", int'(count16), (i < 16) ? i : 16);
      check("d16_almost_full", int'(af16), 0);
      check("d16_full", int'(full16), (i >= 16) ? 1 : 0);
      check("d16_mem_wr_en", int'(wen16), (i < 16) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    wr16 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
